// File: rtl/cntr_div.sv
`default_nettype none
// ============================================================================
// Module      : cntr_div
// Description : Parameterised clock divider. o_clk is a registered square wave
//               with a period of DIV input clocks (low phase = ceil(DIV/2)).
//               Optional macro CNTR_TICK_EN adds a one-cycle o_tick pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module cntr_div #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic o_clk
`ifdef CNTR_TICK_EN
    ,
    output logic o_tick
`endif
);

    // Width guard keeps elaboration sane long enough for the DIV check to fire.
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_low  = CNT_W'((DIV + 1) / 2);

    generate
        if (DIV < 2) begin : g_div_check
            $error("cntr_div: DIV must be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = (r_cnt == c_last) ? '0 : r_cnt + CNT_W'(1);
    end

    // o_clk is taken straight from a flop so downstream stages see clean edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            o_clk <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            o_clk <= (w_cnt_next >= c_low);
        end
    end

`ifdef CNTR_TICK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_tick <= 1'b0;
        end else begin
            o_tick <= (w_cnt_next == '0);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cntr_div.sv
`default_nettype none
// Scoreboard bench for cntr_div: DIV=10, DIV=7 and a DIV=2 -> DIV=3 ripple chain.
module tb_cntr_div;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic o10, o7, o2, o3;
`ifdef CNTR_TICK_EN
    logic t10, t7, t2, t3;
`endif

    cntr_div #(.DIV(10)) u10 (
        .clk   (clk),
        .reset (reset),
        .o_clk (o10)
`ifdef CNTR_TICK_EN
        , .o_tick(t10)
`endif
    );

    cntr_div #(.DIV(7)) u7 (
        .clk   (clk),
        .reset (reset),
        .o_clk (o7)
`ifdef CNTR_TICK_EN
        , .o_tick(t7)
`endif
    );

    cntr_div #(.DIV(2)) u2 (
        .clk   (clk),
        .reset (reset),
        .o_clk (o2)
`ifdef CNTR_TICK_EN
        , .o_tick(t2)
`endif
    );

    // Second stage of the chain is clocked by the first stage's output.
    cntr_div #(.DIV(3)) u3 (
        .clk   (o2),
        .reset (reset),
        .o_clk (o3)
`ifdef CNTR_TICK_EN
        , .o_tick(t3)
`endif
    );

    typedef struct packed {
        logic c10;
        logic c7;
        logic c3;
        logic t10;
        logic t7;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per clock, compared on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            chk("o_clk_div10", o10, e_mon.c10);
            chk("o_clk_div7",  o7,  e_mon.c7);
            chk("o_clk_chain", o3,  e_mon.c3);
`ifdef CNTR_TICK_EN
            chk("o_tick_div10", t10, e_mon.t10);
            chk("o_tick_div7",  t7,  e_mon.t7);
`endif
        end
    end

    // Hand-built phase tables, bit i = expected o_clk when (edge mod DIV) == i.
    logic [9:0] pat10 = 10'b11111_00000;
    logic [6:0] pat7  = 7'b111_0000;
    logic [2:0] pat3  = 3'b100;

    initial begin
        int   k;
        logic rs;
        exp_t e;
        k = 0;
        #1 reset = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk);
            rs = reset;
            if (rs) k++;
            else    k = 0;
            #3;
            if (cyc == 3)   reset = 1'b1;
            if (cyc == 130) begin
                // u10 is mid high phase here (edge 127); reset must clear it at once.
                reset = 1'b0;
                k     = 0;
            end
            if (cyc == 135) reset = 1'b1;
            e.c10 = pat10[k % 10];
            e.c7  = pat7[k % 7];
            e.c3  = pat3[((k + 1) / 2) % 3];
            e.t10 = (k > 0) && (k % 10 == 0);
            e.t7  = (k > 0) && (k % 7 == 0);
            q.push_back(e);
        end
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        if (total == 0) begin
            bad++;
            $display("FAIL no_checks: got 0 comparisons expected >0");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
